// File: rtl/psk_pkg.sv
// Shared types and Gray-map helpers for the PSK symbol scheduler.
package psk_pkg;

  typedef enum logic {
    MODE_QPSK = 1'b0,
    MODE_8PSK = 1'b1
  } psk_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_t;

  localparam int unsigned QPSK_BPS = 2;
  localparam int unsigned PSK8_BPS = 3;

  // QPSK dibit -> phase index on the odd 45-degree points (45/135/225/315 deg).
  function automatic logic [2:0] qpsk_gray(input logic [1:0] bits);
    logic [2:0] ph;
    case (bits)
      2'b00:   ph = 3'b001;
      2'b01:   ph = 3'b011;
      2'b11:   ph = 3'b101;
      2'b10:   ph = 3'b111;
      default: ph = 3'b001;
    endcase
    return ph;
  endfunction

  // 8-PSK tribit -> phase index, adjacent phases differ by one bit.
  function automatic logic [2:0] psk8_gray(input logic [2:0] bits);
    logic [2:0] ph;
    case (bits)
      3'b000:  ph = 3'b000;
      3'b001:  ph = 3'b001;
      3'b011:  ph = 3'b010;
      3'b010:  ph = 3'b011;
      3'b110:  ph = 3'b100;
      3'b111:  ph = 3'b101;
      3'b101:  ph = 3'b110;
      3'b100:  ph = 3'b111;
      default: ph = 3'b000;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/psk_gray_mapper.sv
// Combinational raw-bits to phase-index mapper. QPSK uses raw[1:0] only.
module psk_gray_mapper
  import psk_pkg::*;
(
  input  psk_mode_t  mode,
  input  logic [2:0] raw,
  output logic [2:0] phase
);

  // Pick the constellation map for the latched modulation
  always_comb begin
    phase = qpsk_gray(raw[1:0]);
    if (mode == MODE_8PSK) phase = psk8_gray(raw);
  end

endmodule

// File: rtl/psk_symbol_scheduler.sv
// Serial bit assembler, one-entry pending symbol buffer and hold timer that
// drives a phase multiplexer with gapless PSK symbols.
//
// state | meaning
// IDLE  | no symbol on air, phase_sel = IDLE_PHASE, waiting for pending symbol
// HOLD  | symbol on air, hold counter runs 0..SYM_CYCLES-1
module psk_symbol_scheduler
  import psk_pkg::*;
#(
  parameter int unsigned SYM_CYCLES = 8,
  parameter logic [2:0]  IDLE_PHASE = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       bit_ready,
  output logic [2:0] phase_sel,
  output logic       sym_strobe,
  output logic       tx_active,
  output logic       underrun
);

  localparam logic [7:0] CNT_LAST = 8'(SYM_CYCLES - 1);

  sched_state_t state_q, state_d;
  psk_mode_t    mode_q;
  logic [7:0]   cnt_q;
  logic [1:0]   asm_cnt_q;
  logic [1:0]   asm_bits_q;
  logic         pend_full_q;
  logic [2:0]   pend_phase_q;
  logic [2:0]   phase_q;
  logic         strobe_q;
  logic         underrun_q;

  logic [1:0]   asm_last_idx;
  logic         hold_end;
  logic         consume;
  logic         asm_last;
  logic         accept;
  logic         sym_done;
  logic [2:0]   mapped;

  // Handshake and symbol-boundary decode
  always_comb begin
    asm_last_idx = (mode_q == MODE_8PSK) ? 2'(PSK8_BPS - 1) : 2'(QPSK_BPS - 1);
    hold_end     = (state_q == ST_HOLD) && (cnt_q == CNT_LAST);
    consume      = pend_full_q && ((state_q == ST_IDLE) || hold_end);
    asm_last     = (asm_cnt_q == asm_last_idx);
    // Only stall the bit that would complete a symbol with nowhere to go
    bit_ready    = !(asm_last && pend_full_q && !consume);
    accept       = bit_valid && bit_ready;
    sym_done     = accept && asm_last;
  end

  psk_gray_mapper u_mapper (
    .mode  (mode_q),
    .raw   ({asm_bits_q, bit_data}),
    .phase (mapped)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: leave IDLE on a pending symbol, return when none is ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pend_full_q) state_d = ST_HOLD;
      ST_HOLD: if (hold_end && !pend_full_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Mode latch only when nothing is in flight, so a symbol never mixes maps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_QPSK;
    end else if ((state_q == ST_IDLE) && (asm_cnt_q == 2'd0) && !pend_full_q) begin
      mode_q <= psk_mode_t'(mode);
    end
  end

  // MSB-first assembler and one-entry pending buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_cnt_q    <= 2'd0;
      asm_bits_q   <= 2'b00;
      pend_full_q  <= 1'b0;
      pend_phase_q <= 3'b000;
    end else begin
      if (accept) begin
        asm_bits_q <= {asm_bits_q[0], bit_data};
        asm_cnt_q  <= asm_last ? 2'd0 : asm_cnt_q + 2'd1;
      end
      // A write on the consuming edge wins: the old entry has just left
      if (sym_done) begin
        pend_full_q  <= 1'b1;
        pend_phase_q <= mapped;
      end else if (consume) begin
        pend_full_q <= 1'b0;
      end
    end
  end

  // Hold timer, phase output register and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      phase_q    <= IDLE_PHASE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_q   <= consume;
      underrun_q <= hold_end && !pend_full_q;
      if (consume) begin
        phase_q <= pend_phase_q;
        cnt_q   <= 8'd0;
      end else if (hold_end) begin
        phase_q <= IDLE_PHASE;
        cnt_q   <= 8'd0;
      end else if (state_q == ST_HOLD) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign phase_sel  = phase_q;
  assign sym_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign tx_active  = (state_q == ST_HOLD);

endmodule

// File: doc/psk_symbol_scheduler.md
PSK_SYMBOL_SCHEDULER -- requirements
Module: psk_symbol_scheduler

Interface
REQ-001 Parameter SYM_CYCLES, default 8, clocks each symbol is held on phase_sel; legal range 4..255.
REQ-002 Parameter IDLE_PHASE, default 3'b000, phase_sel value driven when no symbol is being transmitted.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 mode  in  1  0 = QPSK (2 bits/symbol), 1 = 8-PSK (3 bits/symbol); sampled only per REQ-017.
REQ-006 bit_valid  in  1  upstream has a bit on bit_data.
REQ-007 bit_data  in  1  serial payload bit, MSB of each symbol first.
REQ-008 bit_ready  out  1  block accepts bit_data this cycle; transfer = bit_valid & bit_ready.
REQ-009 phase_sel  out  3  phase select to the phase multiplexer, 45 deg per LSB.
REQ-010 sym_strobe  out  1  one-cycle pulse in the first cycle a new symbol appears on phase_sel.
REQ-011 tx_active  out  1  high while FSM is in HOLD.
REQ-012 underrun  out  1  one-cycle pulse when HOLD ends with no pending symbol.

Function
REQ-013 Assembler shall shift accepted bits MSB-first; count runs 0..bps-1, bps = 2 (QPSK) or 3 (8-PSK).
REQ-014 Accepting the last bit of a symbol shall write the Gray-mapped phase into a one-entry pending register and clear the assembler count, same edge.
REQ-015 QPSK map: 00->001, 01->011, 11->101, 10->111 (45/135/225/315 deg).
REQ-016 8-PSK map: 000->000, 001->001, 011->010, 010->011, 110->100, 111->101, 101->110, 100->111.
REQ-017 mode shall be latched into an internal mode register only on edges where FSM is IDLE, assembler count is 0 and pending is empty; otherwise mode changes are ignored.
REQ-018 bit_ready shall be low only when assembler holds bps-1 bits, pending is full and pending is not being consumed that cycle; high otherwise (including IDLE).
REQ-019 FSM states: IDLE, HOLD; hold counter 8 bits.
REQ-020 IDLE: phase_sel = IDLE_PHASE; if pending full, next edge loads phase_sel from pending, empties pending, clears counter, enters HOLD, and sym_strobe is high for the following cycle.
REQ-021 Latency: last bit accepted at edge E -> new phase_sel and sym_strobe visible after edge E+1 when starting from IDLE.
REQ-022 HOLD: counter increments each clock; at counter = SYM_CYCLES-1 with pending full -> load next phase, clear counter, strobe, stay HOLD (gapless back-to-back symbols).
REQ-023 HOLD: at counter = SYM_CYCLES-1 with pending empty -> IDLE, phase_sel = IDLE_PHASE and underrun high for one cycle; partial assembler bits are retained.
REQ-024 Simultaneous pending write (REQ-014) and consume (REQ-022) on one edge shall succeed: new symbol enters pending, old one goes to phase_sel.
REQ-025 sym_strobe and underrun shall never be high in the same cycle.

Reset
REQ-026 rst_n low at an edge: FSM IDLE, counter 0, assembler count 0, pending empty, mode register 0, phase_sel = IDLE_PHASE, sym_strobe 0, underrun 0, tx_active 0, bit_ready 1.
REQ-027 Reset mid-symbol shall discard partial and pending symbols; no strobe or underrun pulse on reset exit.

Structure
REQ-028 Shared package psk_pkg shall hold the mode enum, FSM state enum, and both Gray map constants/functions.
REQ-029 One combinational sub-module psk_gray_mapper (mode, raw bits -> 3-bit phase) shall be instantiated; all other logic stays in psk_symbol_scheduler.

Verification
REQ-030 QPSK, SYM_CYCLES=8, stream bits 0,1 at cycles 0-1 -> phase_sel 011 from cycle 3, sym_strobe at cycle 3 only, IDLE_PHASE and underrun at cycle 11.
REQ-031 8-PSK, continuous bit_valid, bits 110,100,011 -> phase_sel 100,111,010 for 8 clocks each, no gaps, one underrun at end.
REQ-032 QPSK, SYM_CYCLES=4, bit_valid held high -> bit_ready periodically low, no bit lost, strobes exactly every 4 cycles.
REQ-033 mode toggled 0->1 during HOLD -> ignored until IDLE with empty assembler/pending; next symbol uses 3-bit 8-PSK map.
REQ-034 rst_n low for 1 cycle mid-HOLD with 1 bit in assembler and pending full -> all outputs per REQ-026, next 2 QPSK bits produce fresh symbol correctly.
REQ-035 All 8 8-PSK and 4 QPSK codewords driven -> phase_sel matches REQ-015/REQ-016 exactly.
